pattern_scan_ctrl: RTL and testbench

Streaming controller that accepts parallel words over a valid/ready handshake and serialises them MSB-first through an internal programmable 4-bit Moore-style pattern matcher. It is sequenced by a start/done job interface and emits one detect pulse per match. It keeps a saturating match count per job. It sits between a word-oriented producer and the bit-serial sequence-detection datapath, and owns the job sequencing, the flow control and the overlap policy.

---
 rtl/pattern_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit streaming controller with a programmable 4-bit pattern matcher and job sequencing.
// Optional abort input enabled by defining PSCAN_ABORT_EN.
module pattern_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PSCAN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [3:0]       pattern,
  input  logic             overlap,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam int unsigned BitCntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]         hist_q, hist_d;
  logic [2:0]         vcnt_q, vcnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               det_q, det_d;

  logic       bit_in;
  logic [3:0] hist_upd;
  logic [2:0] vcnt_upd;
  logic       hit;

  assign bit_in   = sreg_q[WIDTH-1];
  assign hist_upd = {hist_q[2:0], bit_in};
  assign vcnt_upd = (vcnt_q == 3'd4) ? 3'd4 : vcnt_q + 3'd1;
  assign hit      = (hist_upd == pattern_q) && (vcnt_upd == 3'd4);

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    overlap_d   = overlap_q;
    words_d     = words_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    hist_d      = hist_q;
    vcnt_d      = vcnt_q;
    match_cnt_d = match_cnt_q;
    det_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pattern_d   = pattern;
          overlap_d   = overlap;
          words_d     = num_words;
          hist_d      = 4'd0;
          vcnt_d      = 3'd0;
          match_cnt_d = '0;
          state_d     = (num_words == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          sreg_d    = in_data;
          words_d   = words_q - 1'b1;
          bit_cnt_d = BitCntW'(WIDTH - 1);
          state_d   = StShift;
        end
      end
      StShift: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        hist_d = hist_upd;
        // Non-overlapping mode demands four fresh bits after each match.
        vcnt_d = (hit && !overlap_q) ? 3'd0 : vcnt_upd;
        if (hit) begin
          det_d = 1'b1;
          if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
        end
        if (bit_cnt_q == '0) begin
          state_d = (words_q == '0) ? StDone : StLoad;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef PSCAN_ABORT_EN
    // Abort discards the word in flight and freezes the count as it stood.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      det_d       = 1'b0;
      match_cnt_d = match_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pattern_q   <= 4'd0;
      overlap_q   <= 1'b0;
      words_q     <= '0;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      hist_q      <= 4'd0;
      vcnt_q      <= 3'd0;
      match_cnt_q <= '0;
      det_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      overlap_q   <= overlap_d;
      words_q     <= words_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      hist_q      <= hist_d;
      vcnt_q      <= vcnt_d;
      match_cnt_q <= match_cnt_d;
      det_q       <= det_d;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign det       = det_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: expected det/done cycles are queued as words are driven.
module tb_pattern_scan_ctrl;
  localparam int WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic       overlap;
  logic [7:0] num_words;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, busy, det, done;
  logic [7:0] match_cnt;
  logic       in_ready2, busy2, det2, done2;
  logic [1:0] match_cnt2;
`ifdef PSCAN_ABORT_EN
  logic       abort;
`endif

  int cyc;
  int checks;
  int errors;
  int detq[$];
  int doneq[$];

  pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PSCAN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .pattern(pattern), .overlap(overlap), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .det(det), .match_cnt(match_cnt), .done(done)
  );

  // Narrow-counter twin sees the same stream to exercise saturation.
  pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef PSCAN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .pattern(pattern), .overlap(overlap), .num_words(num_words[1:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .busy(busy2),
    .det(det2), .match_cnt(match_cnt2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Scoreboard consumer: every det/done must match a queued expected cycle.
  always @(negedge clk) begin
    if (det) begin
      if (detq.size() == 0) check_eq("det_unexpected", {31'd0, det}, 32'd0);
      else check_eq("det_cycle", cyc, detq.pop_front());
    end
    if (done) begin
      if (doneq.size() == 0) check_eq("done_unexpected", {31'd0, done}, 32'd0);
      else check_eq("done_cycle", cyc, doneq.pop_front());
    end
  end

  task automatic run_job(input logic [3:0] pat, input logic ov, input int n,
                         input logic [7:0] w0, input logic [7:0] w1);
    logic [3:0] mhist;
    int         mvcnt, mcnt, h, hprev, k;
    logic [7:0] w;
    mhist = 4'd0; mvcnt = 0; mcnt = 0; hprev = 0;
    @(negedge clk);
    start = 1'b1; pattern = pat; overlap = ov; num_words = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      in_valid = 1'b1;
      in_data  = w;
      k = 0;
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
      h = cyc;
      if (i > 0) check_eq("ready_gap", h - hprev, WIDTH + 1);
      hprev = h;
      for (int b = 1; b <= WIDTH; b++) begin
        mhist = {mhist[2:0], w[WIDTH-b]};
        if (mvcnt < 4) mvcnt++;
        if (mhist == pat && mvcnt == 4) begin
          detq.push_back(h + b + 1);
          mcnt++;
          if (!ov) mvcnt = 0;
        end
      end
      if (i == n - 1) doneq.push_back(h + WIDTH + 1);
      @(negedge clk);
      if (i == n - 1) in_valid = 1'b0;
      check_eq("ready_low_after_hs", {31'd0, in_ready}, 32'd0);
    end
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("job_end_idle", {31'd0, busy}, 32'd0);
    check_eq("det_left", detq.size(), 0);
    check_eq("done_left", doneq.size(), 0);
    check_eq("match_cnt", {24'd0, match_cnt}, sat(mcnt, 255));
    check_eq("match_cnt_w2", {30'd0, match_cnt2}, sat(mcnt, 3));
  endtask

  int t, h;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; pattern = 4'd0; overlap = 1'b0; num_words = 8'd0;
    in_valid = 1'b0; in_data = 8'd0;
`ifdef PSCAN_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_det", {31'd0, det}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_match_cnt", {24'd0, match_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_job(4'b1010, 1'b1, 1, 8'hAA, 8'h00);
    run_job(4'b1010, 1'b0, 1, 8'hAA, 8'h00);
    run_job(4'b1010, 1'b1, 2, 8'h0A, 8'h50);

    // Zero-word job, plus a start while busy that must be ignored.
    @(negedge clk);
    start = 1'b1; num_words = 8'd0; pattern = 4'b1010; overlap = 1'b1;
    t = cyc;
    doneq.push_back(t + 1);
    @(negedge clk);
    check_eq("zero_busy", {31'd0, busy}, 32'd1);
    check_eq("zero_ready", {31'd0, in_ready}, 32'd0);
    num_words = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_idle", {31'd0, busy}, 32'd0);
    check_eq("zero_ready2", {31'd0, in_ready}, 32'd0);
    check_eq("zero_match_cnt", {24'd0, match_cnt}, 32'd0);
    @(negedge clk);
    check_eq("ignored_start", {31'd0, busy}, 32'd0);
    check_eq("done_left_zero", doneq.size(), 0);

    run_job(4'b0000, 1'b1, 1, 8'h00, 8'h00);
    for (int r = 0; r < 4; r++) begin
      run_job(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(1, 2),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Reset in the middle of SHIFT, before any match is due.
    @(negedge clk);
    start = 1'b1; pattern = 4'b1111; overlap = 1'b1; num_words = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("midrst_det", {31'd0, det}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_cnt", {24'd0, match_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("postrst_idle", {31'd0, busy}, 32'd0);

`ifdef PSCAN_ABORT_EN
    // Abort while waiting for the second word: count held, no done.
    @(negedge clk);
    start = 1'b1; pattern = 4'b1010; overlap = 1'b1; num_words = 8'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    h = cyc;
    detq.push_back(h + 5);
    detq.push_back(h + 7);
    detq.push_back(h + 9);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    check_eq("abort_in_load", {31'd0, in_ready}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_idle", {31'd0, busy}, 32'd0);
    check_eq("abort_ready", {31'd0, in_ready}, 32'd0);
    check_eq("abort_cnt", {24'd0, match_cnt}, 32'd3);
    repeat (3) @(negedge clk);
    check_eq("abort_det_left", detq.size(), 0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
